// File: rtl/calc_accumulator_stack.sv
// Button-driven accumulator calculator: synchronised execute/undo buttons, eight ops,
// sticky overflow, optional saturation, and a circular undo history.
module calc_accumulator_stack #(
  parameter int ACC_W      = 8,
  parameter int OPND_W     = 3,
  parameter int HIST_DEPTH = 4,
  parameter int SAT_EN     = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            undo,
  input  logic [OPND_W-1:0]               operand,
  input  logic [2:0]                      op,
  output logic [ACC_W-1:0]                acc,
  output logic                            flag_ovf,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CNT_W = $clog2(HIST_DEPTH+1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_XOR = 3'b010, OP_SHL = 3'b011,
    OP_SHR = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_CLR = 3'b111
  } op_e;

  // [0] first sync flop, [1] second sync flop, [2] previous synchronised value
  logic [2:0] en_sync, undo_sync;
  logic       en_pls, undo_pls;

  always_ff @(posedge clock) begin
    if (reset) begin
      en_sync   <= '0;
      undo_sync <= '0;
      en_pls    <= 1'b0;
      undo_pls  <= 1'b0;
    end else begin
      en_sync   <= {en_sync[1], en_sync[0], en};
      undo_sync <= {undo_sync[1], undo_sync[0], undo};
      en_pls    <= en_sync[1] & ~en_sync[2];
      undo_pls  <= undo_sync[1] & ~undo_sync[2];
    end
  end

  logic [ACC_W-1:0] acc_q, opx, shl_v, res;
  logic [ACC_W:0]   sum, dif;
  logic             shl_loss, ovf;

  always_comb begin
    opx      = ACC_W'(operand);
    sum      = {1'b0, acc_q} + {1'b0, opx};
    dif      = {1'b0, acc_q} - {1'b0, opx};
    // shifting by >= ACC_W yields zero, so loss reduces to acc_q != 0 there
    shl_v    = acc_q << operand;
    shl_loss = (shl_v >> operand) != acc_q;
    res      = acc_q;
    ovf      = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        ovf = sum[ACC_W];
        res = (SAT_EN != 0 && ovf) ? '1 : sum[ACC_W-1:0];
      end
      OP_SUB: begin
        ovf = dif[ACC_W];
        res = (SAT_EN != 0 && ovf) ? '0 : dif[ACC_W-1:0];
      end
      OP_XOR: res = acc_q ^ opx;
      OP_SHL: begin
        ovf = shl_loss;
        res = (SAT_EN != 0 && ovf) ? '1 : shl_v;
      end
      OP_SHR: res = acc_q >> operand;
      OP_AND: res = acc_q & opx;
      OP_OR:  res = acc_q | opx;
      default: res = '0;
    endcase
  end

  logic [ACC_W-1:0] hist_mem [HIST_DEPTH];
  logic [PTR_W-1:0] wptr, rptr, wptr_nx;
  logic [CNT_W-1:0] cnt;
  logic             do_undo, do_exec, do_push;

  // wptr names the next slot; when full it also names the oldest entry
  assign rptr    = (wptr == '0) ? PTR_W'(HIST_DEPTH-1) : wptr - 1'b1;
  assign wptr_nx = (wptr == PTR_W'(HIST_DEPTH-1)) ? '0 : wptr + 1'b1;
  assign do_undo = undo_pls;
  assign do_exec = en_pls & ~undo_pls;
  assign do_push = do_exec & (op != OP_CLR);

  always_ff @(posedge clock) begin
    if (!reset && do_push) hist_mem[wptr] <= acc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      flag_ovf <= 1'b0;
      cnt      <= '0;
      wptr     <= '0;
    end else if (do_undo) begin
      if (cnt != '0) begin
        acc_q <= hist_mem[rptr];
        wptr  <= rptr;
        cnt   <= cnt - 1'b1;
      end
    end else if (do_exec) begin
      if (op == OP_CLR) begin
        acc_q    <= '0;
        flag_ovf <= 1'b0;
        cnt      <= '0;
        wptr     <= '0;
      end else begin
        acc_q <= res;
        wptr  <= wptr_nx;
        if (cnt != CNT_W'(HIST_DEPTH)) cnt <= cnt + 1'b1;
        if (ovf) flag_ovf <= 1'b1;
      end
    end
  end

  assign acc        = acc_q;
  assign hist_count = cnt;

endmodule

// File: tb/tb_calc_accumulator_stack.sv
// Scoreboard bench: one wrapping and one saturating instance share the button stimulus;
// expected states are queued by cycle and compared by an independent monitor.
module tb_calc_accumulator_stack;

  logic       clock = 1'b0;
  logic       reset, en, undo;
  logic [2:0] op;
  logic [3:0] operand;
  logic [7:0] acc0, acc1;
  logic       ovf0, ovf1;
  logic [2:0] hc0, hc1;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  calc_accumulator_stack #(.ACC_W(8), .OPND_W(4), .HIST_DEPTH(4), .SAT_EN(0)) dut (
    .clock(clock), .reset(reset), .en(en), .undo(undo), .operand(operand), .op(op),
    .acc(acc0), .flag_ovf(ovf0), .hist_count(hc0));

  calc_accumulator_stack #(.ACC_W(8), .OPND_W(4), .HIST_DEPTH(4), .SAT_EN(1)) dut_sat (
    .clock(clock), .reset(reset), .en(en), .undo(undo), .operand(operand), .op(op),
    .acc(acc1), .flag_ovf(ovf1), .hist_count(hc1));

  typedef struct {
    logic [7:0] a0; logic f0; logic [2:0] h0;
    logic [7:0] a1; logic f1; logic [2:0] h1;
  } st_t;
  typedef struct { int cyc; st_t s; string nm; } ent_t;

  ent_t q[$];
  st_t  cur;
  int   checks = 0, errors = 0;

  function automatic st_t mk(input int a0, f0, h0, a1, f1, h1);
    st_t s;
    s.a0 = a0[7:0]; s.f0 = f0[0]; s.h0 = h0[2:0];
    if (a1 < 0) begin
      s.a1 = a0[7:0]; s.f1 = f0[0]; s.h1 = h0[2:0];
    end else begin
      s.a1 = a1[7:0]; s.f1 = f1[0]; s.h1 = h1[2:0];
    end
    return s;
  endfunction

  task automatic push(input int c, input st_t s, input string nm);
    ent_t e;
    e.cyc = c; e.s = s; e.nm = nm;
    q.push_back(e);
  endtask

  // inputs parked on "clear" between presses: must never be picked up
  task automatic idle();
    op = 3'b111; operand = 4'hF;
  endtask

  // one button press issued at a falling edge; state must change exactly at k+4
  task automatic act(input string nm, input bit ben, input bit bund, input logic [2:0] o,
                     input logic [3:0] d, input int a0, f0, h0,
                     input int a1 = -1, input int f1 = -1, input int h1 = -1);
    int k; st_t nx;
    k = cyc;
    nx = mk(a0, f0, h0, a1, f1, h1);
    en = ben; undo = bund; op = o; operand = d;
    push(k + 3, cur, {nm, "/pre"});
    push(k + 4, nx, nm);
    cur = nx;
    repeat (3) @(negedge clock);
    en = 1'b0; undo = 1'b0;
    @(negedge clock);
    idle();
    repeat (3) @(negedge clock);
  endtask

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ent_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
      end else begin
        checks++;
        if ({acc0, ovf0, hc0} !== {e.s.a0, e.s.f0, e.s.h0}) begin
          errors++;
          $display("FAIL %s wrap @%0d: acc=%0d ovf=%0b hist=%0d, expected acc=%0d ovf=%0b hist=%0d",
                   e.nm, cyc, acc0, ovf0, hc0, e.s.a0, e.s.f0, e.s.h0);
        end
        checks++;
        if ({acc1, ovf1, hc1} !== {e.s.a1, e.s.f1, e.s.h1}) begin
          errors++;
          $display("FAIL %s sat @%0d: acc=%0d ovf=%0b hist=%0d, expected acc=%0d ovf=%0b hist=%0d",
                   e.nm, cyc, acc1, ovf1, hc1, e.s.a1, e.s.f1, e.s.h1);
        end
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; en = 1'b0; undo = 1'b0; idle();
    repeat (2) @(negedge clock);
    cur = mk(0, 0, 0, -1, -1, -1);
    push(cyc + 1, cur, "reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // basic ops and history with undo
    act("add5",  1, 0, 3'b000, 4'd5, 5, 0, 1);
    act("sub2",  1, 0, 3'b001, 4'd2, 3, 0, 2);
    act("xor6",  1, 0, 3'b010, 4'd6, 5, 0, 3);
    act("or8",   1, 0, 3'b110, 4'd8, 13, 0, 4);
    act("and6",  1, 0, 3'b101, 4'd6, 4, 0, 4);
    act("shr1",  1, 0, 3'b100, 4'd1, 2, 0, 4);
    act("undoA", 0, 1, 3'b111, 4'd0, 4, 0, 3);
    act("undoB", 0, 1, 3'b111, 4'd0, 13, 0, 2);
    act("clr1",  1, 0, 3'b111, 4'd0, 0, 0, 0);

    // 250 + 7: wrap vs saturate, undo keeps the flag
    act("add15", 1, 0, 3'b000, 4'd15, 15, 0, 1);
    act("shl4",  1, 0, 3'b011, 4'd4, 240, 0, 2);
    act("add10", 1, 0, 3'b000, 4'd10, 250, 0, 3);
    act("add7",  1, 0, 3'b000, 4'd7, 1, 1, 4, 255, 1, 4);
    act("undoF", 0, 1, 3'b111, 4'd0, 250, 1, 3);
    act("clr2",  1, 0, 3'b111, 4'd0, 0, 0, 0);
    act("sub1",  1, 0, 3'b001, 4'd1, 255, 1, 1, 0, 1, 1);
    act("clr3",  1, 0, 3'b111, 4'd0, 0, 0, 0);

    // shift loss and out-of-range shifts
    act("add8",  1, 0, 3'b000, 4'd8, 8, 0, 1);
    act("shl4b", 1, 0, 3'b011, 4'd4, 128, 0, 2);
    act("add1",  1, 0, 3'b000, 4'd1, 129, 0, 3);
    act("shl1",  1, 0, 3'b011, 4'd1, 2, 1, 4, 255, 1, 4);
    act("shr7",  1, 0, 3'b100, 4'd7, 0, 1, 4, 1, 1, 4);
    act("clr4",  1, 0, 3'b111, 4'd0, 0, 0, 0);
    act("shl9z", 1, 0, 3'b011, 4'd9, 0, 0, 1);
    act("add3",  1, 0, 3'b000, 4'd3, 3, 0, 2);
    act("shl8",  1, 0, 3'b011, 4'd8, 0, 1, 3, 255, 1, 3);
    act("clr5",  1, 0, 3'b111, 4'd0, 0, 0, 0);

    // history depth: six adds, five undos
    for (int i = 1; i <= 6; i++)
      act($sformatf("inc%0d", i), 1, 0, 3'b000, 4'd1, i, 0, (i > 4) ? 4 : i);
    for (int i = 0; i < 5; i++)
      act($sformatf("undo%0d", i), 0, 1, 3'b111, 4'd0, (i < 4) ? 5 - i : 2, 0, (i < 4) ? 3 - i : 0);
    act("clr6",  1, 0, 3'b111, 4'd0, 0, 0, 0);

    // held button fires once
    k = cyc;
    en = 1'b1; op = 3'b000; operand = 4'd1;
    push(k + 3, cur, "held/pre");
    cur = mk(1, 0, 1, -1, -1, -1);
    push(k + 4, cur, "held");
    push(k + 22, cur, "held/once");
    repeat (20) @(negedge clock);
    en = 1'b0; idle();
    repeat (4) @(negedge clock);

    // simultaneous en and undo: undo wins
    act("both",  1, 1, 3'b000, 4'd1, 0, 0, 0);
    act("add5b", 1, 0, 3'b000, 4'd5, 5, 0, 1);

    // reset on the cycle the execute pulse is live
    k = cyc;
    en = 1'b1; op = 3'b000; operand = 4'd1;
    push(k + 3, cur, "rst/pre");
    cur = mk(0, 0, 0, -1, -1, -1);
    push(k + 4, cur, "rst/clr");
    push(k + 8, cur, "rst/hold");
    repeat (3) @(negedge clock);
    reset = 1'b1; en = 1'b0;
    @(negedge clock);
    reset = 1'b0; idle();
    repeat (6) @(negedge clock);

    // clear drops a set flag
    act("sub1b", 1, 0, 3'b001, 4'd1, 255, 1, 1, 0, 1, 1);
    act("clr7",  1, 0, 3'b111, 4'd0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks still pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
